// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit: aligns stores, extends loads,
// stalls the pipeline during a data-memory handshake and times out.
// Ports:
//   clk, rst        : clock, async active-high reset
//   req_valid       : memory-stage op present (held while stall=1)
//   mem_read        : op is a load
//   mem_write       : op is a store
//   funct3          : RV32I width/sign code
//   addr            : byte address from the ALU
//   wdata           : store data (rs2)
//   dmem_req        : memory request, held until dmem_ready
//   dmem_we         : 1 = write
//   dmem_addr       : word-aligned address
//   dmem_be         : byte enables
//   dmem_wdata      : lane-replicated store data
//   dmem_ready      : memory completes the request this cycle
//   dmem_rdata      : read word, valid with dmem_ready
//   load_data       : extended load result (valid with done)
//   stall           : freeze stages up to and including memory
//   done            : one-cycle completion pulse
//   err             : one-cycle fault pulse
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
  logic [31:0] ld_q, ld_d;

  logic        is_load, is_store, legal, misal;
  logic        accept, reject;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] rsh;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ext;

  always_comb begin
    is_load  = mem_read & ~mem_write;
    is_store = mem_write & ~mem_read;
    legal    = 1'b0;
    if (is_load)
      legal = funct3 inside {3'b000, 3'b001, 3'b010,
                             3'b100, 3'b101};
    else if (is_store)
      legal = funct3 inside {3'b000, 3'b001, 3'b010};
    misal = ((funct3[1:0] == 2'b01) & addr[0]) |
            ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    // legal already implies exactly one of read/write
    accept = req_valid & legal & ~misal;
    reject = req_valid & (mem_read | mem_write) & ~accept;
  end

  always_comb begin
    be_n = 4'b1111;
    wd_n = wdata;
    unique case (funct3[1:0])
      2'b00: begin
        be_n = 4'b0001 << addr[1:0];
        wd_n = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_n = 4'b0011 << addr[1:0];
        wd_n = {2{wdata[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = wdata;
      end
    endcase
  end

  always_comb begin
    rsh   = dmem_rdata >> {lane_q, 3'b000};
    rbyte = rsh[7:0];
    rhalf = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (f3_q)
      3'b000:  ext = {{24{rbyte[7]}}, rbyte};
      3'b001:  ext = {{16{rhalf[15]}}, rhalf};
      3'b100:  ext = {24'd0, rbyte};
      3'b101:  ext = {16'd0, rhalf};
      default: ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    ld_d    = ld_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = REQ;
          we_d    = is_store;
          addr_d  = {addr[31:2], 2'b00};
          be_d    = be_n;
          wdata_d = wd_n;
          f3_d    = funct3;
          lane_d  = addr[1:0];
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end
      end
      REQ: begin
        if (dmem_ready) begin
          ld_d    = we_q ? 32'd0 : ext;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            tmo_d   = 1'b1;
            ld_d    = 32'd0;
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      ld_q    <= ld_d;
    end
  end

  // rst gates the combinational outputs so they drop immediately
  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign load_data  = ld_q;
  assign stall      = ~rst & ((state_q == REQ) |
                              ((state_q == IDLE) & accept));
  assign done       = (state_q == DONE);
  assign err        = ~rst & (((state_q == IDLE) & reject) |
                              ((state_q == DONE) & tmo_q));

endmodule
